// File: rtl/biquad_mac_secuencial_pkg.sv
// Shared constants for the sequential biquad stage: FSM encoding, MAC index width
// and the default fixed-point format.
package biquad_mac_secuencial_pkg;
  localparam int WIDTH_DEF = 22;
  localparam int FRAC_DEF  = 14;
  localparam int IDX_W     = 3;
  localparam longint ONE_Q = longint'(1) << FRAC_DEF;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
endpackage

// File: rtl/biquad_mac_secuencial_if.sv
// Sample request, coefficient and result bundle between a biquad stage and its driver.
interface biquad_mac_secuencial_if
  import biquad_mac_secuencial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic                    sample_tick;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] coef_b0;
  logic signed [WIDTH-1:0] coef_b1;
  logic signed [WIDTH-1:0] coef_b2;
  logic signed [WIDTH-1:0] coef_a1;
  logic signed [WIDTH-1:0] coef_a2;
  logic signed [WIDTH-1:0] y_out;
  logic                    y_valid;
  logic                    busy;
  logic                    sat;
  logic                    overrun;

  modport master (
    output sample_tick, x_in, coef_b0, coef_b1, coef_b2, coef_a1, coef_a2,
    input  y_out, y_valid, busy, sat, overrun
  );

  modport slave (
    input  sample_tick, x_in, coef_b0, coef_b1, coef_b2, coef_a1, coef_a2,
    output y_out, y_valid, busy, sat, overrun
  );
endinterface

// File: rtl/biquad_mac_secuencial_redondeo_saturacion.sv
// Combinational round-half-up and clip from accumulator width down to WIDTH.
module redondeo_saturacion
  import biquad_mac_secuencial_pkg::*;
#(
  parameter int IN_W  = 2 * WIDTH_DEF + 3,
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic signed [IN_W-1:0]  acc,
  output logic signed [WIDTH-1:0] y,
  output logic                    sat
);
  localparam logic signed [IN_W:0] HALF  = {{(IN_W-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W-WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W-WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  // One guard bit keeps the half-LSB addition from wrapping at the top of the range.
  function automatic logic signed [IN_W:0] round_half_up(input logic signed [IN_W-1:0] a);
    logic signed [IN_W:0] t;
    t = {a[IN_W-1], a} + HALF;
    return t >>> FRAC;
  endfunction

  function automatic logic [WIDTH:0] saturate(input logic signed [IN_W:0] v);
    if (v > MAX_V)      return {1'b1, MAX_V[WIDTH-1:0]};
    else if (v < MIN_V) return {1'b1, MIN_V[WIDTH-1:0]};
    else                return {1'b0, v[WIDTH-1:0]};
  endfunction

  logic [WIDTH:0] res;

  always_comb begin
    res = saturate(round_half_up(acc));
    sat = res[WIDTH];
    y   = res[WIDTH-1:0];
  end
endmodule

// File: rtl/biquad_mac_secuencial.sv
// Single-multiplier biquad: snapshots x and coefficients on sample_tick, runs five
// time-shared MACs, then rounds, saturates and updates the delay lines.
module biquad_mac_secuencial
  import biquad_mac_secuencial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input logic                     clk,
  input logic                     reset_n,
  biquad_mac_secuencial_if.slave  bus
);
  localparam int PROD_W = 2 * WIDTH;
  localparam int ACC_W  = 2 * WIDTH + 3;

  logic [1:0]              state;
  logic [IDX_W-1:0]        idx;
  logic signed [WIDTH-1:0] x0_s, b0_s, b1_s, b2_s, a1_s, a2_s;
  logic signed [WIDTH-1:0] x1, x2, y1, y2;
  logic signed [WIDTH-1:0] coef_sel, data_sel;
  logic signed [PROD_W-1:0] prod_c, prod_p0;
  logic                    vld_p0;
  logic signed [ACC_W-1:0] acc;
  logic signed [WIDTH-1:0] y_rnd, y_q;
  logic                    sat_rnd, y_valid_q, sat_q, overrun_q;

  always_comb begin
    coef_sel = a2_s;
    data_sel = y2;
    case (idx)
      3'd0: begin coef_sel = b0_s; data_sel = x0_s; end
      3'd1: begin coef_sel = b1_s; data_sel = x1;   end
      3'd2: begin coef_sel = b2_s; data_sel = x2;   end
      3'd3: begin coef_sel = a1_s; data_sel = y1;   end
      default: ;
    endcase
    prod_c = PROD_W'(coef_sel) * PROD_W'(data_sel);
  end

  // Snapshot / product stage: datapath registers without reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.sample_tick) begin
      x0_s <= bus.x_in;
      b0_s <= bus.coef_b0;
      b1_s <= bus.coef_b1;
      b2_s <= bus.coef_b2;
      a1_s <= bus.coef_a1;
      a2_s <= bus.coef_a2;
    end
    if (state == S_MAC) prod_p0 <= prod_c;
  end

  redondeo_saturacion #(.IN_W(ACC_W), .WIDTH(WIDTH), .FRAC(FRAC)) u_rs (
    .acc (acc),
    .y   (y_rnd),
    .sat (sat_rnd)
  );

  // Accumulate / output stage. OUT spends its first cycle draining the last product.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      vld_p0    <= 1'b0;
      acc       <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      sat_q     <= 1'b0;
      if (bus.sample_tick && state != S_IDLE) overrun_q <= 1'b1;
      if (vld_p0) acc <= acc + ACC_W'(prod_p0);
      case (state)
        S_IDLE: begin
          if (bus.sample_tick) begin
            acc   <= '0;
            idx   <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          vld_p0 <= 1'b1;
          idx    <= idx + 3'd1;
          if (idx == 3'd4) state <= S_OUT;
        end
        S_OUT: begin
          vld_p0 <= 1'b0;
          if (!vld_p0) begin
            y_q       <= y_rnd;
            y_valid_q <= 1'b1;
            sat_q     <= sat_rnd;
            x2        <= x1;
            x1        <= x0_s;
            y2        <= y1;
            y1        <= y_rnd;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.y_out   = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.sat     = sat_q;
  assign bus.overrun = overrun_q;
  assign bus.busy    = (state != S_IDLE);
endmodule

// File: tb/tb_biquad_mac_secuencial.sv
// Directed and randomized bench for biquad_mac_secuencial against a difference-equation model.
module tb_biquad_mac_secuencial;
  import biquad_mac_secuencial_pkg::*;

  localparam int W = 22;
  localparam longint YMAX = 2097151;
  localparam longint YMIN = -2097152;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  biquad_mac_secuencial_if #(.WIDTH(W)) bus ();

  biquad_mac_secuencial #(.WIDTH(W), .FRAC(14)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  longint b0, b1, b2, a1, a2;
  longint mx1, mx2, my1, my2;
  longint exp_y;
  logic   exp_sat;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive_coefs();
    bus.coef_b0 = 22'(b0);
    bus.coef_b1 = 22'(b1);
    bus.coef_b2 = 22'(b2);
    bus.coef_a1 = 22'(a1);
    bus.coef_a2 = 22'(a2);
  endtask

  task automatic set_coefs(input longint c0, input longint c1, input longint c2,
                           input longint c3, input longint c4);
    b0 = c0; b1 = c1; b2 = c2; a1 = c3; a2 = c4;
    drive_coefs();
  endtask

  task automatic model_clear();
    mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
  endtask

  // y = sum of five products, round half-up at 2^-14, clip, then shift history.
  task automatic model_step(input longint x);
    longint sum, r;
    sum = b0 * x + b1 * mx1 + b2 * mx2 + a1 * my1 + a2 * my2;
    r = (sum + (ONE_Q / 2)) >>> 14;
    exp_sat = 1'b0;
    if (r > YMAX) begin r = YMAX; exp_sat = 1'b1; end
    if (r < YMIN) begin r = YMIN; exp_sat = 1'b1; end
    exp_y = r;
    mx2 = mx1; mx1 = x;
    my2 = my1; my1 = r;
  endtask

  task automatic run_sample(input string tag, input longint x, input int chg_cycle, input longint chg_b0);
    int lat;
    drive_coefs();
    bus.x_in = 22'(x);
    bus.sample_tick = 1'b1;
    model_step(x);
    @(posedge clk);
    #1 bus.sample_tick = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (c == chg_cycle) begin
        b0 = chg_b0;
        drive_coefs();
      end
      @(posedge clk);
      #1;
      if (bus.y_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, lat, 7);
    check({tag, "_y"}, bus.y_out, exp_y);
    check({tag, "_sat"}, bus.sat, exp_sat);
    @(posedge clk);
    #1;
    check({tag, "_valid_drop"}, bus.y_valid, 1'b0);
    check({tag, "_sat_drop"}, bus.sat, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int nvalid;

    // Reset held with live inputs
    set_coefs(1000, 2000, 3000, 4000, 5000);
    bus.x_in = 22'(12345);
    bus.sample_tick = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_y", bus.y_out, 0);
    check("rst_valid", bus.y_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sat", bus.sat, 0);
    check("rst_overrun", bus.overrun, 0);
    bus.sample_tick = 1'b0;
    reset_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    run_sample("first_after_rst", 700, 0, 0);

    // Pass-through
    set_coefs(16384, 0, 0, 0, 0);
    run_sample("pass_1000", 1000, 0, 0);
    check("pass_1000_lit", bus.y_out, 1000);
    run_sample("pass_0", 0, 0, 0);
    check("pass_0_lit", bus.y_out, 0);

    // Recursion, impulse response halves each sample
    set_coefs(16384, 0, 0, 8192, 0);
    run_sample("rec_0", 16384, 0, 0);
    check("rec_0_lit", bus.y_out, 16384);
    run_sample("rec_1", 0, 0, 0);
    check("rec_1_lit", bus.y_out, 8192);
    run_sample("rec_2", 0, 0, 0);
    run_sample("rec_3", 0, 0, 0);
    check("rec_3_lit", bus.y_out, 2048);

    // Rounding at the half-LSB boundary
    set_coefs(1, 0, 0, 0, 0);
    run_sample("rnd_8192", 8192, 0, 0);
    check("rnd_8192_lit", bus.y_out, 1);
    run_sample("rnd_8191", 8191, 0, 0);
    check("rnd_8191_lit", bus.y_out, 0);
    run_sample("rnd_m8193", -8193, 0, 0);
    check("rnd_m8193_lit", bus.y_out, -1);

    // Saturation both directions
    set_coefs(16384, 16384, 16384, 0, 0);
    for (int i = 0; i < 3; i++) run_sample("sat_pos", YMAX, 0, 0);
    check("sat_pos_lit", bus.y_out, YMAX);
    for (int i = 0; i < 3; i++) run_sample("sat_neg", YMIN, 0, 0);
    check("sat_neg_lit", bus.y_out, YMIN);

    // Coefficient change during MAC uses the snapshot
    set_coefs(16384, 0, 0, 0, 0);
    run_sample("snap_old_b0", 500, 2, 0);
    run_sample("snap_new_b0", 300, 0, 0);

    // Second tick two cycles after the first
    set_coefs(16384, 8192, 0, 4096, 0);
    drive_coefs();
    bus.x_in = 22'(1234);
    bus.sample_tick = 1'b1;
    model_step(1234);
    @(posedge clk);
    #1 bus.sample_tick = 1'b0;
    @(posedge clk);
    #1 bus.sample_tick = 1'b1;
    bus.x_in = 22'(-777);
    @(posedge clk);
    #1 bus.sample_tick = 1'b0;
    nvalid = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (bus.y_valid === 1'b1) begin
        nvalid++;
        check("ovr_y", bus.y_out, exp_y);
      end
    end
    check("ovr_nvalid", nvalid, 1);
    check("ovr_flag", bus.overrun, 1);
    check("ovr_busy", bus.busy, 0);

    // Reset while the MAC is on its fourth product
    set_coefs(9000, -3000, 2500, 6000, -2000);
    bus.x_in = 22'(4321);
    bus.sample_tick = 1'b1;
    @(posedge clk);
    #1 bus.sample_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_clear();
    nvalid = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.y_valid === 1'b1) nvalid++;
    end
    check("midrst_nvalid", nvalid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_overrun", bus.overrun, 0);
    check("midrst_y", bus.y_out, 0);
    run_sample("midrst_clean_hist", 4321, 0, 0);

    // Randomized coefficients and samples
    for (int i = 0; i < 24; i++) begin
      set_coefs(longint'($urandom_range(0, 65535)) - 32768,
                longint'($urandom_range(0, 65535)) - 32768,
                longint'($urandom_range(0, 65535)) - 32768,
                longint'($urandom_range(0, 16383)) - 8192,
                longint'($urandom_range(0, 16383)) - 8192);
      run_sample("rand", longint'($urandom_range(0, 4194303)) - 2097152, 0, 0);
    end

    // Band select off: everything zero
    set_coefs(0, 0, 0, 0, 0);
    run_sample("zero_coef", 150000, 0, 0);
    check("zero_coef_lit", bus.y_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
